// File: rtl/bomb_pkg.sv
// Shared definitions for the bomb field and the player blocks.
package bomb_pkg;

  // Default arena size: last column / last row index.
  localparam int unsigned HMaxTile = 9;
  localparam int unsigned VMaxTile = 5;

  typedef enum logic [1:0] {
    SlotFree  = 2'd0,
    SlotArmed = 2'd1,
    SlotBurn  = 2'd2
  } slot_state_e;

  // Row-major tile index with ncol = last column + 1.
  function automatic int unsigned tile_idx(input int unsigned ncol, input logic [3:0] h,
                                           input logic [3:0] v);
    return ncol * int'(v) + int'(h);
  endfunction

endpackage

// File: rtl/bomb_field_if.sv
// Player requests, wall map and the maps/flags the field hands back.
interface bomb_field_if #(
  parameter int unsigned T = 60
);
  logic         placeA;
  logic [3:0]   hA;
  logic [3:0]   vA;
  logic         placeB;
  logic [3:0]   hB;
  logic [3:0]   vB;
  logic [T-1:0] wallMap;
  logic [T:0]   walkAble;
  logic [T-1:0] flameMap;
  logic         hitA;
  logic         hitB;
  logic [3:0]   liveBombs;

  modport master (
    output placeA, hA, vA, placeB, hB, vB, wallMap,
    input  walkAble, flameMap, hitA, hitB, liveBombs
  );

  modport slave (
    input  placeA, hA, vA, placeB, hB, vB, wallMap,
    output walkAble, flameMap, hitA, hitB, liveBombs
  );
endinterface

// File: rtl/bomb_slot.sv
// One bomb: position, lifecycle state and fuse/flame countdown.
module bomb_slot
  import bomb_pkg::*;
#(
  parameter int unsigned FUSE_TICKS  = 3,
  parameter int unsigned FLAME_TICKS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [3:0]  load_h_i,
  input  logic [3:0]  load_v_i,
  input  logic        tick_i,
  input  logic        chain_hit_i,
  output slot_state_e state_o,
  output logic [3:0]  h_o,
  output logic [3:0]  v_o
);
  localparam int unsigned CtrMax = (FUSE_TICKS > FLAME_TICKS) ? FUSE_TICKS : FLAME_TICKS;
  localparam int unsigned CtrW   = $clog2(CtrMax + 1);

  slot_state_e     state_q, state_d;
  logic [3:0]      h_q, h_d, v_q, v_d;
  logic [CtrW-1:0] ctr_q, ctr_d;

  // Next state: load when free, fuse countdown or chain ignition when armed, flame countdown.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    ctr_d   = ctr_q;
    case (state_q)
      SlotFree: begin
        if (load_i) begin
          state_d = SlotArmed;
          h_d     = load_h_i;
          v_d     = load_v_i;
          ctr_d   = CtrW'(FUSE_TICKS);
        end
      end
      SlotArmed: begin
        if (chain_hit_i) begin
          state_d = SlotBurn;
          ctr_d   = CtrW'(FLAME_TICKS);
        end else if (tick_i) begin
          if (ctr_q > CtrW'(1)) begin
            ctr_d = ctr_q - CtrW'(1);
          end else begin
            state_d = SlotBurn;
            ctr_d   = CtrW'(FLAME_TICKS);
          end
        end
      end
      SlotBurn: begin
        if (tick_i) begin
          if (ctr_q > CtrW'(1)) begin
            ctr_d = ctr_q - CtrW'(1);
          end else begin
            state_d = SlotFree;
            ctr_d   = '0;
          end
        end
      end
      default: begin
        state_d = SlotFree;
        ctr_d   = '0;
      end
    endcase
  end

  // Slot registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SlotFree;
      h_q     <= '0;
      v_q     <= '0;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      ctr_q   <= ctr_d;
    end
  end

  assign state_o = state_q;
  assign h_o     = h_q;
  assign v_o     = v_q;

endmodule

// File: rtl/bomb_field.sv
// Arena bomb manager: allocator, bomb slots, tick prescaler, flame and walk maps.
module bomb_field
  import bomb_pkg::*;
#(
  parameter int unsigned HMAXTILE    = HMaxTile,
  parameter int unsigned VMAXTILE    = VMaxTile,
  parameter int unsigned NSLOT       = 8,
  parameter int unsigned TICK_DIV    = 25000000,
  parameter int unsigned FUSE_TICKS  = 3,
  parameter int unsigned FLAME_TICKS = 1,
  parameter int unsigned RANGE       = 2
) (
  input logic         clk,
  input logic         rst,
  bomb_field_if.slave bus
);
  localparam int unsigned NCol = HMAXTILE + 1;
  localparam int unsigned T    = NCol * (VMAXTILE + 1);
  localparam int unsigned IdxW = $clog2(T);
  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int          NS   = int'(NSLOT);

  function automatic logic [IdxW-1:0] idx(input logic [3:0] h, input logic [3:0] v);
    return IdxW'(tile_idx(NCol, h, v));
  endfunction

  function automatic logic in_range(input logic [3:0] h, input logic [3:0] v);
    return (int'(h) <= int'(HMAXTILE)) && (int'(v) <= int'(VMAXTILE));
  endfunction

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick;

  slot_state_e st [NSLOT];
  logic [3:0]  sh [NSLOT];
  logic [3:0]  sv [NSLOT];
  logic [3:0]  load_h [NSLOT];
  logic [3:0]  load_v [NSLOT];
  logic [NSLOT-1:0] load;
  logic [NSLOT-1:0] chain;

  logic [T-1:0] occ;
  logic [T-1:0] flame;
  logic [3:0]   live;

  // Game-tick prescaler: tick is high in the last cycle of each period.
  always_comb begin
    tick  = (cnt_q == CntW'(TICK_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CntW'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  for (genvar g = 0; g < NS; g++) begin : g_slot
    bomb_slot #(
      .FUSE_TICKS (FUSE_TICKS),
      .FLAME_TICKS(FLAME_TICKS)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load[g]),
      .load_h_i   (load_h[g]),
      .load_v_i   (load_v[g]),
      .tick_i     (tick),
      .chain_hit_i(chain[g]),
      .state_o    (st[g]),
      .h_o        (sh[g]),
      .v_o        (sv[g])
    );
  end

  // Occupancy map and live-bomb count from slot registers.
  always_comb begin
    occ  = '0;
    live = '0;
    for (int s = 0; s < NS; s++) begin
      if (st[s] != SlotFree) begin
        occ[idx(sh[s], sv[s])] = 1'b1;
        live = live + 4'd1;
      end
    end
  end

  // Flame map: centre plus four arms, each arm stopping before a wall or the grid edge.
  always_comb begin
    int   th;
    int   tv;
    logic blocked;
    flame   = '0;
    th      = 0;
    tv      = 0;
    blocked = 1'b0;
    for (int s = 0; s < NS; s++) begin
      if (st[s] == SlotBurn) begin
        flame[idx(sh[s], sv[s])] = 1'b1;
        for (int d = 0; d < 4; d++) begin
          blocked = 1'b0;
          for (int k = 1; k <= int'(RANGE); k++) begin
            th = int'(sh[s]);
            tv = int'(sv[s]);
            case (d)
              0:       th = th - k;
              1:       th = th + k;
              2:       tv = tv - k;
              default: tv = tv + k;
            endcase
            if (th < 0 || th > int'(HMAXTILE) || tv < 0 || tv > int'(VMAXTILE)) begin
              blocked = 1'b1;
            end else if (bus.wallMap[idx(4'(th), 4'(tv))]) begin
              blocked = 1'b1;
            end
            if (!blocked) flame[idx(4'(th), 4'(tv))] = 1'b1;
          end
        end
      end
    end
  end

  // Armed bombs sitting in a flame ignite on the next edge.
  always_comb begin
    chain = '0;
    for (int s = 0; s < NS; s++) begin
      chain[s] = (st[s] == SlotArmed) && flame[idx(sh[s], sv[s])];
    end
  end

  // Allocator: A takes the lowest free slot, B the next one; a shared tile goes to A only.
  always_comb begin
    logic [IdxW-1:0] a_idx, b_idx;
    logic a_ok, b_ok, a_found, b_found, a_take, b_take;
    int   a_slot, b_slot;
    a_idx   = idx(bus.hA, bus.vA);
    b_idx   = idx(bus.hB, bus.vB);
    a_ok    = in_range(bus.hA, bus.vA) && !occ[a_idx] && !flame[a_idx] && !bus.wallMap[a_idx];
    b_ok    = in_range(bus.hB, bus.vB) && !occ[b_idx] && !flame[b_idx] && !bus.wallMap[b_idx];
    a_found = 1'b0;
    b_found = 1'b0;
    a_slot  = 0;
    b_slot  = 0;
    for (int s = 0; s < NS; s++) begin
      if (!a_found && st[s] == SlotFree) begin
        a_found = 1'b1;
        a_slot  = s;
      end
    end
    a_take = bus.placeA && a_ok && a_found;
    for (int s = 0; s < NS; s++) begin
      if (!b_found && st[s] == SlotFree && !(a_take && s == a_slot)) begin
        b_found = 1'b1;
        b_slot  = s;
      end
    end
    b_take = bus.placeB && b_ok && b_found &&
             !(a_take && bus.hA == bus.hB && bus.vA == bus.vB);
    for (int s = 0; s < NS; s++) begin
      load[s]   = (a_take && s == a_slot) || (b_take && s == b_slot);
      load_h[s] = (a_take && s == a_slot) ? bus.hA : bus.hB;
      load_v[s] = (a_take && s == a_slot) ? bus.vA : bus.vB;
    end
  end

  assign bus.walkAble  = {1'b0, ~bus.wallMap & ~occ};
  assign bus.flameMap  = flame;
  assign bus.hitA      = in_range(bus.hA, bus.vA) && flame[idx(bus.hA, bus.vA)];
  assign bus.hitB      = in_range(bus.hB, bus.vB) && flame[idx(bus.hB, bus.vB)];
  assign bus.liveBombs = live;

endmodule

// File: tb/tb_bomb_field.sv
// Directed bench for bomb_field with a 4-cycle game tick.
module tb_bomb_field;
  localparam int T = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   now   = 0;

  always #5 clk = ~clk;

  bomb_field_if #(.T(T)) bus ();

  bomb_field #(
    .HMAXTILE   (9),
    .VMAXTILE   (5),
    .NSLOT      (8),
    .TICK_DIV   (4),
    .FUSE_TICKS (3),
    .FLAME_TICKS(2),
    .RANGE      (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [T-1:0] b(input int i);
    return T'(1) << i;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n posedges (edge count kept in now), then settle on the negedge.
  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      now++;
    end
    @(negedge clk);
  endtask

  task automatic goto_edge(input int k);
    adv(k - now);
  endtask

  task automatic do_reset(input logic [T-1:0] w);
    rst         = 1'b1;
    bus.placeA  = 1'b0;
    bus.placeB  = 1'b0;
    bus.wallMap = w;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    now = 0;
  endtask

  task automatic place(input logic pa, input logic [3:0] ha, input logic [3:0] va,
                       input logic pb, input logic [3:0] hb, input logic [3:0] vb);
    bus.placeA = pa;
    bus.hA     = ha;
    bus.vA     = va;
    bus.placeB = pb;
    bus.hB     = hb;
    bus.vB     = vb;
    adv(1);
    bus.placeA = 1'b0;
    bus.placeB = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [T-1:0] e1, e2, e3, w2, w6;
    e1 = b(12) | b(11) | b(10) | b(13) | b(14) | b(2) | b(22) | b(32);
    e2 = b(12) | b(11) | b(10) | b(2) | b(22) | b(32);
    e3 = e1 | b(4) | b(15) | b(16) | b(24) | b(34);
    w2 = b(13);
    w6 = b(20) | b(45);
    bus.hA = 4'd0; bus.vA = 4'd0; bus.hB = 4'd0; bus.vB = 4'd0;

    // 1: single bomb lifecycle.
    do_reset('0);
    chk("rst_walk", 64'(bus.walkAble), 64'({1'b0, ~T'(0)}));
    chk("rst_flame", 64'(bus.flameMap), 64'd0);
    chk("rst_live", 64'(bus.liveBombs), 64'd0);
    chk("rst_hit", 64'({bus.hitA, bus.hitB}), 64'd0);
    place(1'b1, 4'd2, 4'd1, 1'b0, 4'd0, 4'd0);
    chk("t1_walk12", 64'(bus.walkAble[12]), 64'd0);
    chk("t1_live", 64'(bus.liveBombs), 64'd1);
    goto_edge(11);
    chk("t1_preburn", 64'(bus.flameMap), 64'd0);
    goto_edge(12);
    chk("t1_flame", 64'(bus.flameMap), 64'(e1));
    chk("t1_hitA", 64'(bus.hitA), 64'd1);
    goto_edge(19);
    chk("t1_flame_hold", 64'(bus.flameMap), 64'(e1));
    goto_edge(20);
    chk("t1_flame_off", 64'(bus.flameMap), 64'd0);
    chk("t1_walk12_back", 64'(bus.walkAble[12]), 64'd1);
    chk("t1_live0", 64'(bus.liveBombs), 64'd0);

    // 2: wall on tile 13 cuts the right arm.
    do_reset(w2);
    chk("t2_walk", 64'(bus.walkAble), 64'({1'b0, ~w2}));
    place(1'b1, 4'd2, 4'd1, 1'b0, 4'd0, 4'd0);
    goto_edge(12);
    chk("t2_flame", 64'(bus.flameMap), 64'(e2));

    // 3: chain reaction one cycle after the first explosion.
    do_reset('0);
    place(1'b1, 4'd2, 4'd1, 1'b0, 4'd0, 4'd0);
    goto_edge(8);
    place(1'b1, 4'd4, 4'd1, 1'b0, 4'd0, 4'd0);
    goto_edge(12);
    chk("t3_first", 64'(bus.flameMap), 64'(e1));
    chk("t3_live", 64'(bus.liveBombs), 64'd2);
    goto_edge(13);
    chk("t3_chain", 64'(bus.flameMap), 64'(e3));
    goto_edge(20);
    chk("t3_done_flame", 64'(bus.flameMap), 64'd0);
    chk("t3_done_live", 64'(bus.liveBombs), 64'd0);

    // 4: simultaneous requests.
    do_reset('0);
    place(1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 4'd0);
    chk("t4_same_live", 64'(bus.liveBombs), 64'd1);
    chk("t4_same_walk0", 64'(bus.walkAble[0]), 64'd0);
    place(1'b1, 4'd1, 4'd0, 1'b1, 4'd2, 4'd0);
    chk("t4_pair_live", 64'(bus.liveBombs), 64'd3);
    chk("t4_pair_walk", 64'(bus.walkAble[2:0]), 64'd0);

    // 5: full field, drops, and no reuse of a slot freed in the same cycle.
    do_reset('0);
    place(1'b1, 4'd0, 4'd0, 1'b1, 4'd2, 4'd0);
    place(1'b1, 4'd4, 4'd0, 1'b1, 4'd6, 4'd0);
    place(1'b1, 4'd8, 4'd0, 1'b1, 4'd0, 4'd2);
    adv(1);
    place(1'b1, 4'd9, 4'd5, 1'b1, 4'd7, 4'd5);
    chk("t5_full", 64'(bus.liveBombs), 64'd8);
    place(1'b1, 4'd3, 4'd4, 1'b0, 4'd0, 4'd0);
    chk("t5_drop_live", 64'(bus.liveBombs), 64'd8);
    chk("t5_drop_walk", 64'(bus.walkAble[43]), 64'd1);
    goto_edge(12);
    chk("t5_burn_live", 64'(bus.liveBombs), 64'd8);
    goto_edge(19);
    place(1'b1, 4'd3, 4'd4, 1'b0, 4'd0, 4'd0);
    chk("t5_free_same_cycle", 64'(bus.liveBombs), 64'd2);
    place(1'b1, 4'd3, 4'd4, 1'b0, 4'd0, 4'd0);
    chk("t5_reuse_live", 64'(bus.liveBombs), 64'd3);
    chk("t5_reuse_walk", 64'(bus.walkAble[43]), 64'd0);

    // 6: hit flags and reset mid-burn.
    do_reset(w6);
    place(1'b0, 4'd0, 4'd0, 1'b1, 4'd9, 4'd4);
    bus.hB = 4'd9;
    bus.vB = 4'd5;
    goto_edge(11);
    chk("t6_hitB_pre", 64'(bus.hitB), 64'd0);
    goto_edge(12);
    chk("t6_hitB", 64'(bus.hitB), 64'd1);
    chk("t6_hitA", 64'(bus.hitA), 64'd0);
    rst = 1'b1;
    adv(1);
    chk("t6_rst_flame", 64'(bus.flameMap), 64'd0);
    chk("t6_rst_walk", 64'(bus.walkAble), 64'({1'b0, ~w6}));
    chk("t6_rst_live", 64'(bus.liveBombs), 64'd0);
    chk("t6_rst_hitB", 64'(bus.hitB), 64'd0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
